panda_shift_sequencer: RTL and testbench
========================================

PANDA_SHIFT_SEQUENCER -- requirements
Module: panda_shift_sequencer

Interface
REQ-001 SHALL have parameter Width, default 32: operand and result width in bits.
REQ-002 SHALL have parameter AmountWidth, default $clog2(Width): shift amount width.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_ni  input  1  synchronous, active-low reset.
REQ-005 SHALL have port req_valid_i  input  1  request present.
REQ-006 SHALL have port req_ready_o  output  1  request accepted when high together with req_valid_i.
REQ-007 SHALL have port op_i  input  3  operation: 000 SLL, 001 SRL, 011 SRA, 100 ROL, 101 ROR, all other codes illegal.
REQ-008 SHALL have port operand_i  input  Width  value to shift.
REQ-009 SHALL have port amount_i  input  AmountWidth  shift or rotate amount.
REQ-010 SHALL have port resp_valid_o  output  1  response present.
REQ-011 SHALL have port resp_ready_i  input  1  response consumed when high together with resp_valid_o.
REQ-012 SHALL have port result_o  output  Width  registered result.
REQ-013 SHALL have port illegal_o  output  1  registered flag: the op was illegal.

Function
REQ-014 SHALL contain exactly one panda_shifter instance, and every pass SHALL use it.
REQ-015 SHALL implement FSM states IDLE, PASS1, PASS2 and RESP.
REQ-016 SHALL drive req_ready_o high only in IDLE; a handshake SHALL latch op_i, operand_i and amount_i and move the FSM to PASS1.
REQ-017 If a request is accepted at cycle T: in PASS1 (T+1), the shifter SHALL be fed from the latched op and operand, and its output SHALL be stored in a partial register.
REQ-018 Ops SLL/SRL/SRA SHALL go from PASS1 to RESP, so resp_valid_o rises at T+2; SRA SHALL set arithmetic, SLL SHALL set left.
REQ-019 ROL: PASS1 = logical left by amount; PASS2 = logical right by (Width - amount) mod 2^AmountWidth.
REQ-020 ROR: PASS1 = logical right by amount; PASS2 = logical left by (Width - amount) mod 2^AmountWidth.
REQ-021 For both rotates, the result SHALL be partial OR PASS2 output, and resp_valid_o SHALL rise at T+3.
REQ-022 A rotate amount of 0 SHALL take no special path: both passes return the operand, so the result equals the operand.
REQ-023 An illegal op SHALL go from PASS1 to RESP with result_o = 0 and illegal_o = 1, at latency T+2; legal ops SHALL set illegal_o = 0.
REQ-024 In RESP, resp_valid_o, result_o and illegal_o SHALL stay stable until resp_ready_i is high; on that handshake the FSM SHALL return to IDLE.
REQ-025 req_ready_o SHALL go high in the cycle after the response handshake; a new request SHALL NOT be accepted in the same cycle as a response handshake.
REQ-026 req_valid_i, op_i, operand_i and amount_i SHALL be ignored outside IDLE, and changes to them after acceptance SHALL NOT affect the result.
REQ-027 resp_valid_o SHALL be high only in RESP.

Reset
REQ-028 When rst_ni is low at a rising edge, the FSM SHALL go to IDLE, resp_valid_o = 0, result_o = 0, illegal_o = 0 and partial = 0, from any state, including mid-PASS1/PASS2 or RESP.
REQ-029 An in-flight operation interrupted by reset SHALL be discarded and no response SHALL be produced for it; req_ready_o SHALL be high in the first cycle after rst_ni returns high.

Configuration
REQ-030 Macro PANDA_SHIFT_ROTATE_EN: when defined, ROL/ROR SHALL behave as in REQ-019 to REQ-022.
REQ-031 When PANDA_SHIFT_ROTATE_EN is undefined, the PASS2 state and its logic SHALL be absent, and ops 100/101 SHALL be treated as illegal per REQ-023.

Verification
REQ-032 SLL 0x00000001 by 4, accepted at T -> resp_valid_o at T+2, result_o 0x00000010, illegal_o 0.
REQ-033 SRA 0x80000000 by 31 -> result_o 0xFFFFFFFF; SRL with the same inputs -> 0x00000001.
REQ-034 With PANDA_SHIFT_ROTATE_EN: ROL 0x80000001 by 1 -> 0x00000003 at T+3; ROR 0x12345678 by 8 -> 0x78123456; ROL 0xA5A5A5A5 by 0 -> 0xA5A5A5A5. Without the macro: ROL -> illegal_o 1, result_o 0 at T+2.
REQ-035 Illegal op 010 with operand 0xFFFFFFFF -> illegal_o 1, result_o 0x00000000 at T+2.
REQ-036 Backpressure: resp_ready_i held low 3 cycles -> result_o stable, req_ready_o 0, and a new req_valid_i is ignored; on release, req_ready_o is high the next cycle.
REQ-037 Reset: rst_ni low during PASS2 of ROR -> next cycle in IDLE with resp_valid_o 0 and result_o 0, and no response for the discarded op.

Source files
------------

// File: rtl/panda_shift_sequencer.sv
// -----------------------------------------------------------------------------
// panda_shift_sequencer
//
// Multi-cycle shift/rotate unit built around a single barrel shifter
// (panda_shifter). Plain shifts (SLL/SRL/SRA) take one pass through the
// shifter. Rotates (ROL/ROR) take two passes: a logical shift by `amount`,
// then the opposite logical shift by (Width - amount) mod 2^AmountWidth.
// The two partial results are OR-ed together.
//
// Configuration macro:
//   PANDA_SHIFT_ROTATE_EN  defined   -> ROL (100) / ROR (101) supported
//                          undefined -> no second pass; 100/101 are illegal
//
// Ports:
//   clk_i         in   clock, rising edge
//   rst_ni        in   synchronous active-low reset
//   req_valid_i   in   request present
//   req_ready_o   out  unit idle, request accepted on valid & ready
//   op_i          in   [2:0] 000 SLL, 001 SRL, 011 SRA, 100 ROL, 101 ROR
//   operand_i     in   [Width-1:0] value to shift
//   amount_i      in   [AmountWidth-1:0] shift/rotate amount
//   resp_valid_o  out  response present (held until resp_ready_i)
//   resp_ready_i  in   response consumed on valid & ready
//   result_o      out  [Width-1:0] registered result (0 for illegal ops)
//   illegal_o     out  registered illegal-op flag
// -----------------------------------------------------------------------------

// Log-depth barrel shifter: stage gi shifts by 2^gi when amount[gi] is set.
// Right shifts fill with the sign bit when arithmetic is high.
module panda_shifter #(
    parameter int Width       = 32,
    parameter int AmountWidth = $clog2(Width)
) (
    input  logic [Width-1:0]       operand,
    input  logic [AmountWidth-1:0] amount,
    input  logic                   left,
    input  logic                   arithmetic,
    output logic [Width-1:0]       result
);
    logic [Width-1:0] stage [AmountWidth+1];

    assign stage[0] = operand;

    for (genvar gi = 0; gi < AmountWidth; gi++) begin : g_stage
        localparam int unsigned Sh = 2 ** gi;
        logic        [Width-1:0] sll_val;
        logic        [Width-1:0] srl_val;
        logic signed [Width-1:0] sra_val;

        assign sll_val = stage[gi] << Sh;
        assign srl_val = stage[gi] >> Sh;
        // Kept in its own signed net so the >>> is not demoted to a logical
        // shift by the unsigned operands of the select below.
        assign sra_val = $signed(stage[gi]) >>> Sh;

        assign stage[gi+1] = !amount[gi] ? stage[gi] :
                             left        ? sll_val   :
                             arithmetic  ? sra_val   : srl_val;
    end

    assign result = stage[AmountWidth];
endmodule

module panda_shift_sequencer #(
    parameter int Width       = 32,
    parameter int AmountWidth = $clog2(Width)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [2:0]             op_i,
    input  logic [Width-1:0]       operand_i,
    input  logic [AmountWidth-1:0] amount_i,
    output logic                   resp_valid_o,
    input  logic                   resp_ready_i,
    output logic [Width-1:0]       result_o,
    output logic                   illegal_o
);
    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b011;
`ifdef PANDA_SHIFT_ROTATE_EN
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;
    // Width reduced modulo 2^AmountWidth; second-pass amount wraps with it,
    // so a rotate by 0 shifts by 0 in both passes.
    localparam logic [AmountWidth-1:0] WidthMod = AmountWidth'(Width);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
`ifdef PANDA_SHIFT_ROTATE_EN
        PASS2 = 2'd2,
`endif
        RESP  = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [2:0]             op_reg;
    logic [Width-1:0]       operand_reg;
    logic [AmountWidth-1:0] amount_reg;
    logic [Width-1:0]       result_reg, result_next;
    logic                   illegal_reg, illegal_next;
`ifdef PANDA_SHIFT_ROTATE_EN
    // First-pass output of a rotate; only a second pass ever consumes it.
    logic [Width-1:0]       partial_reg, partial_next;
`endif

    logic [AmountWidth-1:0] sh_amount;
    logic                   sh_left;
    logic                   sh_arith;
    logic [Width-1:0]       sh_result;
    logic                   op_legal;
    logic                   op_rotate;

    panda_shifter #(
        .Width       (Width),
        .AmountWidth (AmountWidth)
    ) u_shifter (
        .operand    (operand_reg),
        .amount     (sh_amount),
        .left       (sh_left),
        .arithmetic (sh_arith),
        .result     (sh_result)
    );

    always_comb begin
        op_legal  = (op_reg == OP_SLL) || (op_reg == OP_SRL) || (op_reg == OP_SRA);
        op_rotate = 1'b0;
`ifdef PANDA_SHIFT_ROTATE_EN
        op_rotate = (op_reg == OP_ROL) || (op_reg == OP_ROR);
        op_legal  = op_legal || op_rotate;
`endif
    end

    always_comb begin
        state_next   = state_reg;
        result_next  = result_reg;
        illegal_next = illegal_reg;
        sh_amount    = amount_reg;
        sh_left      = 1'b0;
        sh_arith     = 1'b0;
`ifdef PANDA_SHIFT_ROTATE_EN
        partial_next = partial_reg;
`endif
        unique case (state_reg)
            IDLE: begin
                if (req_valid_i) state_next = PASS1;
            end
            PASS1: begin
                sh_left  = (op_reg == OP_SLL);
                sh_arith = (op_reg == OP_SRA);
`ifdef PANDA_SHIFT_ROTATE_EN
                if (op_reg == OP_ROL) sh_left = 1'b1;
                partial_next = sh_result;
`endif
                if (!op_legal) begin
                    result_next  = '0;
                    illegal_next = 1'b1;
                    state_next   = RESP;
`ifdef PANDA_SHIFT_ROTATE_EN
                end else if (op_rotate) begin
                    state_next = PASS2;
`endif
                end else begin
                    result_next  = sh_result;
                    illegal_next = 1'b0;
                    state_next   = RESP;
                end
            end
`ifdef PANDA_SHIFT_ROTATE_EN
            PASS2: begin
                // Opposite direction to the first pass, always logical.
                sh_amount    = WidthMod - amount_reg;
                sh_left      = (op_reg == OP_ROR);
                result_next  = partial_reg | sh_result;
                illegal_next = 1'b0;
                state_next   = RESP;
            end
`endif
            RESP: begin
                if (resp_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg   <= IDLE;
            result_reg  <= '0;
            illegal_reg <= 1'b0;
`ifdef PANDA_SHIFT_ROTATE_EN
            partial_reg <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            result_reg  <= result_next;
            illegal_reg <= illegal_next;
`ifdef PANDA_SHIFT_ROTATE_EN
            partial_reg <= partial_next;
`endif
        end
    end

    // Request capture; inputs are only looked at on the accepting edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            op_reg      <= '0;
            operand_reg <= '0;
            amount_reg  <= '0;
        end else if (state_reg == IDLE && req_valid_i) begin
            op_reg      <= op_i;
            operand_reg <= operand_i;
            amount_reg  <= amount_i;
        end
    end

    assign req_ready_o  = (state_reg == IDLE);
    assign resp_valid_o = (state_reg == RESP);
    assign result_o     = result_reg;
    assign illegal_o    = illegal_reg;
endmodule

// File: tb/tb_panda_shift_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for panda_shift_sequencer (Width = 32). Directed cases followed by
// random operations with random response backpressure, checked against a
// behavioural model of the shift/rotate semantics and response latency.
// -----------------------------------------------------------------------------
module tb_panda_shift_sequencer;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  op_i;
    logic [31:0] operand_i;
    logic [4:0]  amount_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] result_o;
    logic        illegal_o;

    int checks = 0;
    int errors = 0;

`ifdef PANDA_SHIFT_ROTATE_EN
    localparam bit RotEn = 1'b1;
`else
    localparam bit RotEn = 1'b0;
`endif

    panda_shift_sequencer #(.Width(32), .AmountWidth(5)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .op_i         (op_i),
        .operand_i    (operand_i),
        .amount_i     (amount_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .result_o     (result_o),
        .illegal_o    (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_illegal(input logic [2:0] op);
        case (op)
            3'd0, 3'd1, 3'd3: return 1'b0;
            3'd4, 3'd5:       return !RotEn;
            default:          return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] x,
                                                 input logic [4:0] a);
        logic [63:0]        d;
        logic signed [31:0] s;
        d = {x, x};
        if (model_illegal(op)) return 32'h0;
        case (op)
            3'd0: return x << a;
            3'd1: return x >> a;
            3'd3: begin s = $signed(x) >>> a; return s; end
            3'd4: begin d = d << a; return d[63:32]; end
            default: begin d = d >> a; return d[31:0]; end
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] op);
        if (!model_illegal(op) && (op == 3'd4 || op == 3'd5)) return 3;
        return 2;
    endfunction

    task automatic scramble_inputs();
        op_i      = 3'($urandom);
        operand_i = $urandom;
        amount_i  = 5'($urandom);
    endtask

    // One full transaction: accept, wait response, hold bp cycles, handshake.
    task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [4:0] a,
                          input int bp);
        logic [31:0] er;
        bit          ei;
        int          n;
        er = model_result(op, x, a);
        ei = model_illegal(op);
        n  = 0;
        while (!req_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("req_ready_idle", req_ready_o, 1);
        req_valid_i = 1'b1;
        op_i        = op;
        operand_i   = x;
        amount_i    = a;
        @(negedge clk_i);
        // Inputs after acceptance must not matter.
        req_valid_i = 1'($urandom);
        scramble_inputs();
        n = 1;
        while (!resp_valid_o && n < 10) begin
            check("req_ready_busy", req_ready_o, 0);
            @(negedge clk_i);
            scramble_inputs();
            n++;
        end
        check("latency", n, model_latency(op));
        check("result", result_o, er);
        check("illegal", illegal_o, ei);
        for (int i = 0; i < bp; i++) begin
            req_valid_i = 1'b1;
            scramble_inputs();
            @(negedge clk_i);
            check("bp_resp_valid", resp_valid_o, 1);
            check("bp_result", result_o, er);
            check("bp_illegal", illegal_o, ei);
            check("bp_req_ready", req_ready_o, 0);
        end
        // Handshake with req_valid high: must not start a new op this edge.
        resp_ready_i = 1'b1;
        req_valid_i  = 1'b1;
        @(negedge clk_i);
        resp_ready_i = 1'b0;
        req_valid_i  = 1'b0;
        check("post_req_ready", req_ready_o, 1);
        check("post_resp_valid", resp_valid_o, 0);
        $display("op=%0d operand=%08h amount=%0d bp=%0d -> result=%08h illegal=%0d latency=%0d",
                 op, x, a, bp, result_o, illegal_o, model_latency(op));
    endtask

    initial begin
        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        resp_ready_i = 1'b0;
        op_i         = '0;
        operand_i    = '0;
        amount_i     = '0;
        repeat (2) @(negedge clk_i);
        check("rst_resp_valid", resp_valid_o, 0);
        check("rst_result", result_o, 0);
        check("rst_illegal", illegal_o, 0);
        check("rst_req_ready", req_ready_o, 1);
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_op(3'd0, 32'h0000_0001, 5'd4,  0);
        run_op(3'd3, 32'h8000_0000, 5'd31, 3);
        run_op(3'd1, 32'h8000_0000, 5'd31, 1);
        run_op(3'd4, 32'h8000_0001, 5'd1,  0);
        run_op(3'd5, 32'h1234_5678, 5'd8,  2);
        run_op(3'd4, 32'hA5A5_A5A5, 5'd0,  0);
        run_op(3'd2, 32'hFFFF_FFFF, 5'd7,  1);
        run_op(3'd5, 32'hDEAD_BEEF, 5'd0,  0);
        run_op(3'd0, 32'h0000_0001, 5'd4,  0);

        // Reset in flight: ROR in its second pass (or RESP without rotates).
        req_valid_i = 1'b1;
        op_i        = 3'd5;
        operand_i   = 32'h1234_5678;
        amount_i    = 5'd8;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        @(negedge clk_i);
        check("inflight_resp_valid", resp_valid_o, RotEn ? 1'b0 : 1'b1);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("midreset_resp_valid", resp_valid_o, 0);
        check("midreset_result", result_o, 0);
        check("midreset_illegal", illegal_o, 0);
        rst_ni = 1'b1;
        check("midreset_req_ready", req_ready_o, 1);
        resp_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("discarded_no_resp", resp_valid_o, 0);
            check("discarded_req_ready", req_ready_o, 1);
        end
        resp_ready_i = 1'b0;

        for (int k = 0; k < 40; k++) begin
            run_op(3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)),
                   $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
